// File: rtl/gate_truth_sequencer.sv
// gate_truth_sequencer
// Sweeps an external 2-input gate through the combinations 00, 01, 10, 11,
// holding each for SETTLE cycles. It captures the gate output into table_out
// and compares the result against an expected table latched at start.
//
// Parameters:
//   SETTLE     cycles each combination is held before sampling (1..15)
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request one sweep (sampled only in IDLE)
//   abort      synchronous cancel while busy
//   expected   expected truth table, bit i = output for a=i[1], b=i[0]
//   gate_s     output of the gate under test
//   gate_a/b   registered operand drive to the gate
//   busy       high in DRIVE and CHECK
//   done       single-cycle pulse when results are valid
//   table_out  captured truth table
//   pass       table_out == latched expected
//   fail_mask  table_out ^ latched expected
module gate_truth_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] expected,
  input  logic       gate_s,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] table_out,
  output logic       pass,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] exp_q, exp_d;
  logic [3:0] table_q, table_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_q, fail_d;
  logic       gate_a_q, gate_a_d;
  logic       gate_b_q, gate_b_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      table_q  <= '0;
      pass_q   <= 1'b0;
      fail_q   <= '0;
      gate_a_q <= 1'b0;
      gate_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      table_q  <= table_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      gate_a_q <= gate_a_d;
      gate_b_q <= gate_b_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    table_d  = table_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    gate_a_d = 1'b0;
    gate_b_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          exp_d   = expected;
          table_d = '0;
          pass_d  = 1'b0;
          fail_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
          table_d = '0;
          pass_d  = 1'b0;
          fail_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          table_d[idx_q] = gate_s;
          cnt_d          = '0;
          if (idx_q == 2'd3) begin
            state_d = CHECK;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CHECK: begin
        if (abort) begin
          state_d = IDLE;
          table_d = '0;
          pass_d  = 1'b0;
          fail_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          pass_d  = (table_q == exp_q);
          fail_d  = table_q ^ exp_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Operands are registered, so they are loaded with the index the next
    // cycle will use; this keeps the drive aligned with the DRIVE cycles.
    if (state_d == DRIVE) begin
      gate_a_d = idx_d[1];
      gate_b_d = idx_d[0];
    end
  end

  assign gate_a    = gate_a_q;
  assign gate_b    = gate_b_q;
  assign busy      = (state_q == DRIVE) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign table_out = table_q;
  assign pass      = pass_q;
  assign fail_mask = fail_q;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
module tb_gate_truth_sequencer;

  logic clk;
  logic rst_n;

  // SETTLE=1 instance driving a gate s = a | ~b
  logic       start1, abort1, gs1, ga1, gb1, busy1, done1, pass1;
  logic [3:0] expected1, tbl1, fm1;
  // SETTLE=3 instance driving a NAND gate
  logic       start3, abort3, gs3, ga3, gb3, busy3, done3, pass3;
  logic [3:0] expected3, tbl3, fm3;

  assign gs1 = ga1 | ~gb1;
  assign gs3 = ~(ga3 & gb3);

  gate_truth_sequencer #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .expected(expected1), .gate_s(gs1), .gate_a(ga1), .gate_b(gb1),
    .busy(busy1), .done(done1), .table_out(tbl1), .pass(pass1),
    .fail_mask(fm1)
  );

  gate_truth_sequencer #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .expected(expected3), .gate_s(gs3), .gate_a(ga3), .gate_b(gb3),
    .busy(busy3), .done(done3), .table_out(tbl3), .pass(pass3),
    .fail_mask(fm3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Scoreboard: {table, pass, fail_mask}, pushed at start, popped on done.
  typedef struct packed {
    logic [3:0] tbl;
    logic       p;
    logic [3:0] fm;
  } result_t;
  result_t sb[$];

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        result_t r;
        r = sb.pop_front();
        chk("sb_table", 32'(tbl1), 32'(r.tbl));
        chk("sb_pass", 32'(pass1), 32'(r.p));
        chk("sb_fail_mask", 32'(fm1), 32'(r.fm));
      end
    end
  end

  typedef struct {
    logic [3:0] exp_in;
    logic [3:0] tbl;
    logic       p;
    logic [3:0] fm;
  } vec_t;

  // One sweep on dut1; start is accepted on the edge ending cycle T.
  // The expected input is scrambled during the sweep to prove it is latched.
  task automatic sweep1(input vec_t v, input bit retrig, input bit with_abort);
    int done_at;
    int ndone;
    @(negedge clk);
    start1 = 1'b1; abort1 = with_abort; expected1 = v.exp_in;
    sb.push_back('{tbl: v.tbl, p: v.p, fm: v.fm});
    @(posedge clk); #1;
    start1 = 1'b0; abort1 = 1'b0; expected1 = ~v.exp_in;
    done_at = 0; ndone = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k <= 4) chk("drive_ab", 32'({ga1, gb1}), 32'(k - 1));
      if (k == 1) chk("busy_t1", 32'(busy1), 32'd1);
      if (k == 6) chk("idle_ab", 32'({ga1, gb1}), 32'd0);
      if (retrig && k == 2) start1 = 1'b1;
      if (k == 3) start1 = 1'b0;
      if (done1) begin ndone++; done_at = k; end
    end
    chk("done_cycle", 32'(done_at), 32'd6);
    chk("done_count", 32'(ndone), 32'd1);
    chk("hold_table", 32'(tbl1), 32'(v.tbl));
  endtask

  vec_t vecs[4];

  initial begin
    int ndone;
    int done_at;
    vecs[0] = '{exp_in: 4'b1101, tbl: 4'b1101, p: 1'b1, fm: 4'b0000};
    vecs[1] = '{exp_in: 4'b0111, tbl: 4'b1101, p: 1'b0, fm: 4'b1010};
    vecs[2] = '{exp_in: 4'b0000, tbl: 4'b1101, p: 1'b0, fm: 4'b1101};
    vecs[3] = '{exp_in: 4'b1111, tbl: 4'b1101, p: 1'b0, fm: 4'b0010};

    rst_n = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; expected1 = '0;
    start3 = 1'b0; abort3 = 1'b0; expected3 = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs1", 32'({ga1, gb1, busy1, done1, tbl1, pass1, fm1}), 32'd0);
    chk("reset_outs3", 32'({ga3, gb3, busy3, done3, tbl3, pass3, fm3}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven sweeps
    for (int i = 0; i < 4; i++) sweep1(vecs[i], 1'b0, 1'b0);

    // Restart attempt at T+2 is ignored
    sweep1(vecs[1], 1'b1, 1'b0);
    // start and abort together in IDLE: start wins
    sweep1(vecs[0], 1'b0, 1'b1);

    // SETTLE=3, NAND gate
    @(negedge clk);
    start3 = 1'b1; expected3 = 4'b0111;
    @(posedge clk); #1;
    start3 = 1'b0; expected3 = 4'b0000;
    done_at = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k <= 12) chk("settle3_ab", 32'({ga3, gb3}), 32'((k - 1) / 3));
      if (done3 && done_at == 0) done_at = k;
    end
    chk("settle3_done", 32'(done_at), 32'd14);
    chk("settle3_pass", 32'(pass3), 32'd1);
    chk("settle3_table", 32'(tbl3), 32'b0111);
    chk("settle3_fm", 32'(fm3), 32'd0);

    // Abort at T+3
    @(negedge clk);
    start1 = 1'b1; expected1 = 4'b1101;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    abort1 = 1'b1;
    @(posedge clk); #1;
    abort1 = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_ab", 32'({ga1, gb1}), 32'd0);
    chk("abort_table", 32'(tbl1), 32'd0);
    chk("abort_pass_fm", 32'({pass1, fm1}), 32'd0);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done1) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    sweep1(vecs[0], 1'b0, 1'b0);

    // Asynchronous reset mid-cycle T+2
    @(negedge clk);
    start1 = 1'b1; expected1 = 4'b1101;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_busy", 32'(busy1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", 32'({ga1, gb1, busy1, done1, tbl1, pass1, fm1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done1) ndone++;
    end
    chk("reset_no_done", 32'(ndone), 32'd0);
    chk("reset_idle", 32'(busy1), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
